// File: rtl/sram_frame_reader_if.sv
// Control and pixel-stream bundle between a frame reader and its client.
// The client (master) starts frames and consumes pixels; the reader (slave) produces them.
interface sram_frame_reader_if;
  logic        start;
  logic [19:0] frame_base;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        busy;
  logic        frame_done;

  modport master (
    output start, frame_base, pix_ready,
    input  pix_valid, pix_data, busy, frame_done
  );

  modport slave (
    input  start, frame_base, pix_ready,
    output pix_valid, pix_data, busy, frame_done
  );
endinterface

// File: rtl/sram_frame_reader.sv
// Streams one frame of 16-bit words out of an async SRAM through a small prefetch FIFO.
// Exactly one SRAM read is in flight at a time; DQ is never driven by this block.
module sram_frame_reader #(
  parameter int FRAME_WORDS = 307200,
  parameter int READ_WAIT   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_frame_reader_if.slave pix_if,
  output logic [19:0]        SRAM_ADDR,
  output logic               SRAM_CE_N,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_LB_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_WE_N
);
  localparam int REM_W  = $clog2(FRAME_WORDS + 1);
  localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WAIT_SPACE,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [19:0]       addr_q, addr_d;
  logic [19:0]       sram_addr_q, sram_addr_d;
  logic [REM_W-1:0]  remaining_q, remaining_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              push, pop, pix_valid;
  logic [15:0]       fifo_mem [FIFO_DEPTH];

  assign pix_valid = (count_q != '0);

  always_comb begin
    push = (state_q == S_CAPTURE);
    pop  = pix_valid && pix_if.pix_ready;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    state_d      = state_q;
    addr_d       = addr_q;
    sram_addr_d  = sram_addr_q;
    remaining_d  = remaining_q;
    wait_cnt_d   = '0;
    // busy stays up through the frame_done cycle, so a start there is ignored
    busy_d       = busy_q && !frame_done_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pix_if.start && !busy_q) begin
          addr_d      = pix_if.frame_base;
          remaining_d = REM_W'(FRAME_WORDS);
          busy_d      = 1'b1;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        if (wait_cnt_q == WAIT_W'(READ_WAIT - 1)) begin
          state_d = S_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_CAPTURE: begin
        addr_d      = addr_q + 20'd1;
        remaining_d = remaining_q - REM_W'(1);
        if (remaining_q == REM_W'(1)) begin
          state_d = S_DRAIN;
        end else if (count_d < CNT_W'(FIFO_DEPTH)) begin
          state_d = S_READ;
        end else begin
          state_d = S_WAIT_SPACE;
        end
      end
      S_WAIT_SPACE: begin
        if (count_d < CNT_W'(FIFO_DEPTH)) begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if (count_d == '0) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The bus address only moves when a new access begins; it holds during gaps.
    if (state_d == S_READ && state_q != S_READ) begin
      sram_addr_d = addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      sram_addr_q  <= '0;
      remaining_q  <= '0;
      wait_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sram_addr_q  <= sram_addr_d;
      remaining_q  <= remaining_d;
      wait_cnt_q   <= wait_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= SRAM_DQ;
    end
  end

  assign pix_if.pix_valid  = pix_valid;
  assign pix_if.pix_data   = pix_valid ? fifo_mem[rd_ptr_q] : 16'h0000;
  assign pix_if.busy       = busy_q;
  assign pix_if.frame_done = frame_done_q;

  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_OE_N = !((state_q == S_READ) || (state_q == S_CAPTURE));
  assign SRAM_CE_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_WE_N = 1'b1;
  assign SRAM_DQ   = 16'hzzzz;
endmodule

// File: tb/tb_sram_frame_reader.sv
// Bench for sram_frame_reader: several instances with different frame sizes and read waits,
// each attached to an SRAM model whose word at address A is A[15:0].
module tb_sram_frame_reader;
  localparam int N = 4;

  function automatic int fw_of(input int i);
    case (i)
      0:       return 4;
      1:       return 8;
      2:       return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int rw_of(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] start_v;
  logic [N-1:0] ready_v;
  logic [19:0]  base_v [N];
  wire  [N-1:0] valid_v, busy_v, done_v, oe_n_v, we_n_v, ce_n_v, lb_n_v, ub_n_v;
  wire  [15:0]  data_v [N];
  wire  [19:0]  addr_v [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    sram_frame_reader_if pif ();
    wire [15:0] dq;
    assign pif.start      = start_v[gi];
    assign pif.frame_base = base_v[gi];
    assign pif.pix_ready  = ready_v[gi];
    assign valid_v[gi]    = pif.pix_valid;
    assign data_v[gi]     = pif.pix_data;
    assign busy_v[gi]     = pif.busy;
    assign done_v[gi]     = pif.frame_done;
    assign dq = oe_n_v[gi] ? 16'hzzzz : addr_v[gi][15:0];

    sram_frame_reader #(
      .FRAME_WORDS (fw_of(gi)),
      .READ_WAIT   (rw_of(gi)),
      .FIFO_DEPTH  (4)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pix_if    (pif.slave),
      .SRAM_ADDR (addr_v[gi]),
      .SRAM_CE_N (ce_n_v[gi]),
      .SRAM_DQ   (dq),
      .SRAM_LB_N (lb_n_v[gi]),
      .SRAM_OE_N (oe_n_v[gi]),
      .SRAM_UB_N (ub_n_v[gi]),
      .SRAM_WE_N (we_n_v[gi])
    );
  end

  int total = 0;
  int bad   = 0;

  // Observations collected by run_frame for the calling test to judge
  logic [15:0] got_pix [$];
  logic [15:0] stall_data [$];
  logic [19:0] win_addr [$];
  int          win_len [$];
  int          first_valid, done_cnt, done_cyc, last_xfer, first_gap, we_low, tie_bad;
  logic        busy_c0, busy_c1, busy_after, post_valid, post_busy, post_oe_n;

  // mode: 0 ready always high, 1 ready low until cycle 'stall', 2 random ready
  task automatic run_frame(input int sel, input logic [19:0] base, input int mode, input int stall,
                           input int extra_c, input logic [19:0] base2, input int abort_n);
    logic prev_oe_n;
    int   c;
    bit   stop;
    got_pix.delete(); stall_data.delete(); win_addr.delete(); win_len.delete();
    first_valid = -1; done_cnt = 0; done_cyc = -1; last_xfer = -1; first_gap = -1;
    we_low = 0; tie_bad = 0;
    busy_c0 = 1'b1; busy_c1 = 1'b0; busy_after = 1'b1;
    post_valid = 1'b1; post_busy = 1'b1; post_oe_n = 1'b0;
    prev_oe_n = 1'b1; c = 0; stop = 1'b0;
    while (!stop && c < 400) begin
      @(negedge clk);
      if (abort_n >= 0 && got_pix.size() == abort_n) begin
        start_v[sel] = 1'b0;
        ready_v[sel] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        post_valid = valid_v[sel];
        post_busy  = busy_v[sel];
        post_oe_n  = oe_n_v[sel];
        for (int k = 0; k < 8; k++) begin
          if (done_v[sel]) done_cnt++;
          @(negedge clk);
        end
        stop = 1'b1;
      end else begin
        start_v[sel] = (c == 0) || (c == extra_c);
        base_v[sel]  = (c == extra_c) ? base2 : base;
        case (mode)
          0:       ready_v[sel] = 1'b1;
          1:       ready_v[sel] = (c >= stall);
          default: ready_v[sel] = 1'($urandom_range(0, 1));
        endcase
        if (c == 0) busy_c0 = busy_v[sel];
        if (c == 1) busy_c1 = busy_v[sel];
        if (valid_v[sel]) begin
          if (first_valid < 0) first_valid = c;
          if (ready_v[sel]) begin
            got_pix.push_back(data_v[sel]);
            last_xfer = c;
          end else begin
            stall_data.push_back(data_v[sel]);
          end
        end
        if (done_v[sel]) begin
          done_cnt++;
          if (done_cyc < 0) done_cyc = c;
        end
        if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy_v[sel];
        if (!we_n_v[sel]) we_low++;
        if (ce_n_v[sel] || lb_n_v[sel] || ub_n_v[sel]) tie_bad++;
        if (!oe_n_v[sel]) begin
          if (prev_oe_n || win_addr.size() == 0 || addr_v[sel] != win_addr[win_addr.size() - 1]) begin
            win_addr.push_back(addr_v[sel]);
            win_len.push_back(1);
          end else begin
            win_len[win_len.size() - 1] = win_len[win_len.size() - 1] + 1;
          end
        end else if (!prev_oe_n && first_gap < 0) begin
          first_gap = win_addr.size();
        end
        prev_oe_n = oe_n_v[sel];
        if (done_cyc >= 0 && c >= done_cyc + 6) stop = 1'b1;
        c++;
      end
    end
    start_v[sel] = 1'b0;
    ready_v[sel] = 1'b0;
    $display("frame: dut=%0d base=%05h words_out=%0d done_pulses=%0d windows=%0d",
             sel, base, got_pix.size(), done_cnt, win_addr.size());
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++; if (valid_v[i] !== 1'b0) begin bad++; $display("FAIL reset_valid dut=%0d got=%b exp=0", i, valid_v[i]); end
      total++; if (data_v[i] !== 16'h0000) begin bad++; $display("FAIL reset_data dut=%0d got=%h exp=0000", i, data_v[i]); end
      total++; if (busy_v[i] !== 1'b0) begin bad++; $display("FAIL reset_busy dut=%0d got=%b exp=0", i, busy_v[i]); end
      total++; if (done_v[i] !== 1'b0) begin bad++; $display("FAIL reset_done dut=%0d got=%b exp=0", i, done_v[i]); end
      total++; if (addr_v[i] !== 20'h00000) begin bad++; $display("FAIL reset_addr dut=%0d got=%h exp=00000", i, addr_v[i]); end
      total++; if (oe_n_v[i] !== 1'b1) begin bad++; $display("FAIL reset_oe_n dut=%0d got=%b exp=1", i, oe_n_v[i]); end
      total++; if (we_n_v[i] !== 1'b1) begin bad++; $display("FAIL reset_we_n dut=%0d got=%b exp=1", i, we_n_v[i]); end
    end
  endtask

  task automatic test_basic();
    logic [19:0] a;
    run_frame(0, 20'h00100, 0, 0, -1, 20'h0, -1);
    total++; if (got_pix.size() != 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", got_pix.size()); end
    for (int i = 0; i < got_pix.size() && i < 4; i++) begin
      a = 20'h00100 + 20'(i);
      total++; if (got_pix[i] !== a[15:0]) begin bad++; $display("FAIL basic_pix[%0d] got=%h exp=%h", i, got_pix[i], a[15:0]); end
    end
    total++; if (first_valid != 3) begin bad++; $display("FAIL basic_first_valid got=%0d exp=3", first_valid); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    total++; if (done_cyc != last_xfer + 1) begin bad++; $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, last_xfer + 1); end
    total++; if (done_cyc != 2 * 4 + 2) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=10", done_cyc); end
    total++; if (busy_c0 !== 1'b0 || busy_c1 !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got=%b%b exp=01", busy_c0, busy_c1); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL basic_busy_fall got=%b exp=0", busy_after); end
    total++; if (first_gap != 4) begin bad++; $display("FAIL basic_no_gap got=%0d exp=4", first_gap); end
    total++; if (we_low != 0 || tie_bad != 0) begin bad++; $display("FAIL basic_ties we_low=%0d tie_bad=%0d exp=0,0", we_low, tie_bad); end
  endtask

  task automatic test_backpressure();
    logic [19:0] a;
    run_frame(1, 20'h00100, 1, 20, -1, 20'h0, -1);
    total++; if (got_pix.size() != 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", got_pix.size()); end
    for (int i = 0; i < got_pix.size() && i < 8; i++) begin
      a = 20'h00100 + 20'(i);
      total++; if (got_pix[i] !== a[15:0]) begin bad++; $display("FAIL bp_pix[%0d] got=%h exp=%h", i, got_pix[i], a[15:0]); end
    end
    total++; if (first_gap != 4) begin bad++; $display("FAIL bp_captures_before_full got=%0d exp=4", first_gap); end
    total++; if (stall_data.size() == 0) begin bad++; $display("FAIL bp_stall_seen got=0 exp>0"); end
    for (int i = 0; i < stall_data.size(); i++) begin
      total++; if (stall_data[i] !== 16'h0100) begin bad++; $display("FAIL bp_hold[%0d] got=%h exp=0100", i, stall_data[i]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_wrap();
    logic [19:0] a;
    run_frame(0, 20'hFFFFE, 0, 0, -1, 20'h0, -1);
    total++; if (win_addr.size() != 4) begin bad++; $display("FAIL wrap_windows got=%0d exp=4", win_addr.size()); end
    for (int i = 0; i < win_addr.size() && i < 4; i++) begin
      a = 20'hFFFFE + 20'(i);
      total++; if (win_addr[i] !== a) begin bad++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, win_addr[i], a); end
      total++; if (got_pix.size() > i && got_pix[i] !== a[15:0]) begin bad++; $display("FAIL wrap_pix[%0d] got=%h exp=%h", i, got_pix[i], a[15:0]); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [19:0] a;
    run_frame(0, 20'h00100, 0, 0, 4, 20'h50000, -1);
    total++; if (got_pix.size() != 4) begin bad++; $display("FAIL busy_start_count got=%0d exp=4", got_pix.size()); end
    for (int i = 0; i < got_pix.size() && i < 4; i++) begin
      a = 20'h00100 + 20'(i);
      total++; if (got_pix[i] !== a[15:0]) begin bad++; $display("FAIL busy_start_pix[%0d] got=%h exp=%h", i, got_pix[i], a[15:0]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL busy_start_done got=%0d exp=1", done_cnt); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL busy_start_idle got=%b exp=0", busy_after); end
    // start coinciding with the frame_done pulse (cycle 10 for 4 words at full rate)
    run_frame(0, 20'h00200, 0, 0, 10, 20'h50000, -1);
    total++; if (done_cyc != 10) begin bad++; $display("FAIL done_start_cycle got=%0d exp=10", done_cyc); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL done_start_count got=%0d exp=1", done_cnt); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL done_start_ignored got=%b exp=0", busy_after); end
  endtask

  task automatic test_abort();
    logic [19:0] a;
    run_frame(0, 20'h00200, 0, 0, -1, 20'h0, 2);
    total++; if (post_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", post_valid); end
    total++; if (post_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", post_busy); end
    total++; if (post_oe_n !== 1'b1) begin bad++; $display("FAIL abort_oe_n got=%b exp=1", post_oe_n); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    run_frame(0, 20'h00300, 0, 0, -1, 20'h0, -1);
    total++; if (got_pix.size() != 4) begin bad++; $display("FAIL abort_restart_count got=%0d exp=4", got_pix.size()); end
    for (int i = 0; i < got_pix.size() && i < 4; i++) begin
      a = 20'h00300 + 20'(i);
      total++; if (got_pix[i] !== a[15:0]) begin bad++; $display("FAIL abort_restart_pix[%0d] got=%h exp=%h", i, got_pix[i], a[15:0]); end
    end
  endtask

  task automatic test_slow_random();
    logic [19:0] base, a;
    base = 20'($urandom_range(0, 20'hFFFFF));
    run_frame(2, base, 2, 0, -1, 20'h0, -1);
    total++; if (got_pix.size() != 16) begin bad++; $display("FAIL slow_count got=%0d exp=16", got_pix.size()); end
    total++; if (win_addr.size() != 16) begin bad++; $display("FAIL slow_windows got=%0d exp=16", win_addr.size()); end
    for (int i = 0; i < 16; i++) begin
      a = base + 20'(i);
      if (i < got_pix.size()) begin
        total++; if (got_pix[i] !== a[15:0]) begin bad++; $display("FAIL slow_pix[%0d] got=%h exp=%h", i, got_pix[i], a[15:0]); end
      end
      if (i < win_addr.size()) begin
        total++; if (win_addr[i] !== a) begin bad++; $display("FAIL slow_addr[%0d] got=%h exp=%h", i, win_addr[i], a); end
        total++; if (win_len[i] != 4) begin bad++; $display("FAIL slow_window_len[%0d] got=%0d exp=4", i, win_len[i]); end
      end
    end
    total++; if (we_low != 0) begin bad++; $display("FAIL slow_we_n got=%0d low cycles exp=0", we_low); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL slow_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_random_frames();
    logic [19:0] base, a;
    for (int r = 0; r < 3; r++) begin
      base = 20'($urandom_range(0, 20'hFFFFF));
      run_frame(0, base, 2, 0, -1, 20'h0, -1);
      total++; if (got_pix.size() != 4) begin bad++; $display("FAIL rand_count[%0d] got=%0d exp=4", r, got_pix.size()); end
      for (int i = 0; i < got_pix.size() && i < 4; i++) begin
        a = base + 20'(i);
        total++; if (got_pix[i] !== a[15:0]) begin bad++; $display("FAIL rand_pix[%0d][%0d] got=%h exp=%h", r, i, got_pix[i], a[15:0]); end
      end
      total++; if (done_cnt != 1 || done_cyc != last_xfer + 1) begin bad++; $display("FAIL rand_done[%0d] got=%0d@%0d exp=1@%0d", r, done_cnt, done_cyc, last_xfer + 1); end
    end
  endtask

  task automatic test_single_word();
    logic [19:0] base;
    base = 20'($urandom_range(0, 20'hFFFFF));
    run_frame(3, base, 0, 0, -1, 20'h0, -1);
    total++; if (win_addr.size() != 1) begin bad++; $display("FAIL single_windows got=%0d exp=1", win_addr.size()); end
    total++; if (got_pix.size() != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got_pix.size()); end
    total++; if (got_pix.size() > 0 && got_pix[0] !== base[15:0]) begin bad++; $display("FAIL single_pix got=%h exp=%h", got_pix[0], base[15:0]); end
    total++; if (done_cnt != 1 || done_cyc != 4) begin bad++; $display("FAIL single_done got=%0d@%0d exp=1@4", done_cnt, done_cyc); end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = '0;
    ready_v = '0;
    for (int i = 0; i < N; i++) base_v[i] = 20'h0;
    repeat (3) @(posedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_backpressure();
    test_wrap();
    test_start_while_busy();
    test_abort();
    test_slow_random();
    test_random_frames();
    test_single_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_frame_reader.md
Name: sram_frame_reader

Overview:
Reads one frame of 16-bit pixels out of the off-chip SRAM and streams it to the display path over a valid/ready handshake. It is the read-side counterpart of the camera write path, which fills the same SRAM from DVAL-qualified sensor data. A small prefetch FIFO hides SRAM access latency from the consumer. Only one word is ever in flight on the SRAM bus.

Parameters:
FRAME_WORDS, 307200, number of 16-bit words per frame (1..2^20)
READ_WAIT, 1, cycles that the address and OE_N are held before DQ is sampled (>=1)
FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse that begins a frame read; ignored while busy=1
frame_base  in  20  first SRAM word address, sampled on an accepted start
pix_valid  out  1  FIFO head holds a valid pixel
pix_ready  in  1  consumer accepts the pixel; a transfer occurs when valid and ready are both 1
pix_data  out  16  FIFO head data
busy  out  1  high from the cycle after an accepted start until frame_done
frame_done  out  1  one-cycle pulse after the last word is transferred out
SRAM_ADDR  out  20  SRAM word address
SRAM_CE_N  out  1  tied 0
SRAM_DQ  inout  16  always high-Z from this block (read only)
SRAM_LB_N  out  1  tied 0
SRAM_OE_N  out  1  output enable, active low
SRAM_UB_N  out  1  tied 0
SRAM_WE_N  out  1  tied 1

Behaviour:
- All state changes on posedge clk. rst_n=0 at any edge: state goes to IDLE, FIFO is flushed, counters are cleared. Outputs after reset: pix_valid=0, pix_data=0, busy=0, frame_done=0, SRAM_ADDR=0, SRAM_OE_N=1.
- States: IDLE, READ, CAPTURE, WAIT_SPACE, DRAIN.
- IDLE: on start=1, latch addr=frame_base and remaining=FRAME_WORDS, then go to READ. busy=1 from the next cycle.
- READ: SRAM_ADDR=addr and OE_N=0, held for READ_WAIT cycles, then go to CAPTURE.
- CAPTURE: OE_N stays 0 and the address is held. Sample SRAM_DQ and push it into the FIFO. Then addr = addr+1 mod 2^20 (wraps 0xFFFFF to 0x00000) and remaining decrements.
  - Next state: if remaining becomes 0, go to DRAIN.
  - Else if the post-push/post-pop FIFO count is less than FIFO_DEPTH, go to READ.
  - Else go to WAIT_SPACE.
- WAIT_SPACE: OE_N=1. Go to READ on the first cycle count<FIFO_DEPTH.
- DRAIN: OE_N=1. When the FIFO is empty (after the final pop), pulse frame_done for 1 cycle, set busy=0 and go to IDLE.
- OE_N=1 in IDLE, WAIT_SPACE and DRAIN. SRAM_ADDR holds its last value outside READ/CAPTURE.
- Latency with READ_WAIT=1: start at T0, READ at T1, CAPTURE at T2, pix_valid=1 at T3. Sustained rate is one word per READ_WAIT+1 cycles.
- FIFO rules:
  - A push and a pop in the same cycle leave the count unchanged.
  - A push is never issued when full; a pop is never issued when empty.
  - pix_data and pix_valid stay stable while pix_valid=1 and pix_ready=0.
- A start while busy is ignored and has no effect on the frame in progress.
- If start is asserted in the same cycle that frame_done is pulsed, it is ignored (busy is still 1 in that cycle).
- FRAME_WORDS=1: exactly one SRAM access, then DRAIN.
- A reset mid-frame aborts the frame: any pending words are discarded and no frame_done is issued.

Test Plan:
1. FRAME_WORDS=4, base=0x00100, SRAM model word=addr[15:0], pix_ready=1 -> pix_data 0x0100,0x0101,0x0102,0x0103; first pix_valid at start+3; frame_done exactly once, 1 cycle after the last transfer; busy low afterwards.
2. FRAME_WORDS=8, pix_ready=0 for 20 cycles then 1 -> OE_N goes high after 4 captures (FIFO full, state WAIT_SPACE); pix_data held at 0x0100 while stalled; all 8 words delivered in order, none lost or duplicated.
3. base=0xFFFFE, FRAME_WORDS=4 -> SRAM_ADDR sequence 0xFFFFE,0xFFFFF,0x00000,0x00001.
4. Second start pulse mid-frame with base=0x50000 -> ignored; the original 4-word sequence completes and frame_done pulses exactly once.
5. rst_n=0 for 1 cycle after 2 words delivered -> next cycle pix_valid=0, busy=0, OE_N=1; no frame_done; a new start then reads a full frame from its new base.
6. READ_WAIT=3, random pix_ready toggling, FRAME_WORDS=16 -> every SRAM_ADDR/OE_N=0 window lasts 4 cycles; WE_N=1 and DQ=Z throughout; all 16 words delivered in order.
